// File: rtl/apb_bridge_pkg.sv
// Shared types for the AHB-to-APB bridge APB-side sequencer.
//   apb_state_e : sequencer phase (IDLE, SETUP, ACCESS)
//   CNT_W       : width of the ACCESS wait counter (ACCESS_WAIT is 0..15)
//   apb_rsp_t   : registered response record {err, rdata}
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int CNT_W      = 4;
  localparam int RSP_DATA_W = 32;

  typedef struct packed {
    logic                  err;
    logic [RSP_DATA_W-1:0] rdata;
  } apb_rsp_t;

endpackage

// File: rtl/apb_slave_decode.sv
// Combinational APB slave decoder.
//   addr : transfer address; slave index is addr[ADDR_W-1:SEL_LSB]
//   sel  : one-hot slave select, all zero when the index is out of range
//   hit  : 1 when the index selects one of the NUM_SLAVES slaves
module apb_slave_decode #(
  parameter int ADDR_W     = 32,
  parameter int SEL_LSB    = 12,
  parameter int NUM_SLAVES = 4
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit
);

  localparam int IDX_W = ADDR_W - SEL_LSB;

  logic [IDX_W-1:0] idx;
  logic             unused_low_bits;

  assign idx             = addr[ADDR_W-1:SEL_LSB];
  // Offset bits within a slave window play no part in the decode.
  assign unused_low_bits = ^addr[SEL_LSB-1:0];

  // Each select bit matches exactly one index value, so sel can never be multi-hot;
  // any index >= NUM_SLAVES leaves every bit clear.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = (idx == IDX_W'(i));
    end
  end

  assign hit = |sel;

endmodule

// File: rtl/apb_bridge_ctrl.sv
// APB-side sequencer of the AHB-to-APB bridge.
// Accepts single transfers over req_valid/req_ready, decodes the target slave,
// runs the APB SETUP/ACCESS phases and returns one in-order response per request.
// Out-of-range addresses get an error response and never touch the APB.
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : request handshake (req_ready combinational)
//   req_addr/req_write/req_wdata  : request payload
//   rsp_valid/rsp_err/rsp_rdata   : one-cycle response pulse, registered
//   Pselx/Penable/Pwrite/Paddr/Pwdata : registered APB master outputs
//   Prdata                        : APB read data, sampled in the last ACCESS cycle
module apb_bridge_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int SEL_LSB     = 12,
  parameter int ACCESS_WAIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  req_write,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [NUM_SLAVES-1:0] Pselx,
  output logic                  Penable,
  output logic                  Pwrite,
  output logic [ADDR_W-1:0]     Paddr,
  output logic [DATA_W-1:0]     Pwdata,
  input  logic [DATA_W-1:0]     Prdata
);

  apb_state_e            state, nxt_state;
  logic [CNT_W-1:0]      cnt, nxt_cnt;
  logic                  err_pend, nxt_err_pend;
  logic [NUM_SLAVES-1:0] nxt_sel;
  logic                  nxt_en, nxt_write, nxt_rsp_valid;
  logic [ADDR_W-1:0]     nxt_addr;
  logic [DATA_W-1:0]     nxt_wdata;
  apb_rsp_t              rsp_q, nxt_rsp;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_hit, accept;

  apb_slave_decode #(
    .ADDR_W     (ADDR_W),
    .SEL_LSB    (SEL_LSB),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_decode (
    .addr (req_addr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  // A new request can be taken while idle, or in the final ACCESS cycle so that
  // back-to-back transfers skip the IDLE state. A deferred error blocks intake
  // until it has been reported.
  assign req_ready = !rst && !err_pend &&
                     ((state == IDLE) || ((state == ACCESS) && (cnt == '0)));
  assign accept    = req_valid && req_ready;

  assign rsp_err   = rsp_q.err;
  assign rsp_rdata = DATA_W'(rsp_q.rdata);

  always_comb begin
    nxt_state     = state;
    nxt_cnt       = cnt;
    nxt_err_pend  = err_pend;
    nxt_sel       = Pselx;
    nxt_en        = Penable;
    nxt_write     = Pwrite;
    nxt_addr      = Paddr;
    nxt_wdata     = Pwdata;
    nxt_rsp_valid = 1'b0;
    nxt_rsp       = '0;

    case (state)
      IDLE: begin
        if (err_pend) begin
          // Error deferred behind the previous transfer's response.
          nxt_rsp_valid = 1'b1;
          nxt_rsp.err   = 1'b1;
          nxt_err_pend  = 1'b0;
        end else if (accept) begin
          if (dec_hit) begin
            nxt_state = SETUP;
            nxt_sel   = dec_sel;
            nxt_en    = 1'b0;
            nxt_addr  = req_addr;
            nxt_write = req_write;
            nxt_wdata = req_wdata;
          end else begin
            nxt_rsp_valid = 1'b1;
            nxt_rsp.err   = 1'b1;
          end
        end
      end

      SETUP: begin
        nxt_state = ACCESS;
        nxt_en    = 1'b1;
        nxt_cnt   = CNT_W'(ACCESS_WAIT);
      end

      ACCESS: begin
        if (cnt != '0) begin
          nxt_cnt = cnt - CNT_W'(1);
        end else begin
          // Last ACCESS cycle: Prdata is captured here; Pwrite still belongs
          // to the finishing transfer even if a new one is latched at this edge.
          nxt_rsp_valid = 1'b1;
          nxt_rsp.rdata = Pwrite ? '0 : RSP_DATA_W'(Prdata);
          if (accept && dec_hit) begin
            nxt_state = SETUP;
            nxt_sel   = dec_sel;
            nxt_en    = 1'b0;
            nxt_addr  = req_addr;
            nxt_write = req_write;
            nxt_wdata = req_wdata;
          end else begin
            nxt_state    = IDLE;
            nxt_sel      = '0;
            nxt_en       = 1'b0;
            nxt_err_pend = accept;
          end
        end
      end

      default: begin
        nxt_state = IDLE;
        nxt_sel   = '0;
        nxt_en    = 1'b0;
      end
    endcase
  end

  // Register stage: sequencer state, APB outputs and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      err_pend  <= 1'b0;
      Pselx     <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      err_pend  <= nxt_err_pend;
      Pselx     <= nxt_sel;
      Penable   <= nxt_en;
      Pwrite    <= nxt_write;
      Paddr     <= nxt_addr;
      Pwdata    <= nxt_wdata;
      rsp_valid <= nxt_rsp_valid;
      rsp_q     <= nxt_rsp;
    end
  end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Bench for apb_bridge_ctrl: two instances (ACCESS_WAIT 0 and 2), a vector table
// of isolated transfers, hand-written multi-cycle sequences and a randomized run
// checked against a transaction-schedule reference model.
module tb_apb_bridge_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        req_write [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_err   [2];
  logic [31:0] rsp_rdata [2];
  logic [3:0]  Pselx     [2];
  logic        Penable   [2];
  logic        Pwrite    [2];
  logic [31:0] Paddr     [2];
  logic [31:0] Pwdata    [2];
  logic [31:0] Prdata    [2];

  apb_bridge_ctrl #(.ACCESS_WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_write(req_write[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]), .rsp_rdata(rsp_rdata[0]),
    .Pselx(Pselx[0]), .Penable(Penable[0]), .Pwrite(Pwrite[0]), .Paddr(Paddr[0]),
    .Pwdata(Pwdata[0]), .Prdata(Prdata[0]));

  apb_bridge_ctrl #(.ACCESS_WAIT(2)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_write(req_write[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]), .rsp_rdata(rsp_rdata[1]),
    .Pselx(Pselx[1]), .Penable(Penable[1]), .Pwrite(Pwrite[1]), .Paddr(Paddr[1]),
    .Pwdata(Pwdata[1]), .Prdata(Prdata[1]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic [3:0]  sel;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  // Isolated transfer from IDLE; starts and ends just after a rising edge.
  task automatic single(input int d, input int aw, input vec_t v, input string tag);
    logic [3:0] esel;
    logic       een, erv;
    req_valid[d] = 1'b1;
    req_addr[d]  = v.addr;
    req_write[d] = v.wr;
    req_wdata[d] = v.wdata;
    Prdata[d]    = v.prdata;
    #4;
    chk({tag, "_ready"}, req_ready[d], 1);
    tick();
    req_valid[d] = 1'b0;
    for (int k = 1; k <= aw + 3; k++) begin
      #4;
      esel = (v.sel != 0 && k <= aw + 2) ? v.sel : 4'b0000;
      een  = (v.sel != 0 && k >= 2 && k <= aw + 2);
      erv  = (v.sel != 0) ? (k == aw + 3) : (k == 1);
      chk({tag, "_sel"}, Pselx[d], esel);
      chk({tag, "_en"}, Penable[d], een);
      chk({tag, "_rspv"}, rsp_valid[d], erv);
      if (k == 1 && v.sel != 0) begin
        chk({tag, "_paddr"}, Paddr[d], v.addr);
        chk({tag, "_pwrite"}, Pwrite[d], v.wr);
        chk({tag, "_pwdata"}, Pwdata[d], v.wdata);
      end
      if (erv) begin
        chk({tag, "_err"}, rsp_err[d], v.err);
        chk({tag, "_rdata"}, rsp_rdata[d], v.rdata);
      end
      tick();
    end
  endtask

  // Reference model: a per-cycle schedule of what each accepted request must
  // produce, filled in at accept time from the transfer timing rules.
  localparam int NCYC = 300;
  localparam int NA   = NCYC + 40;
  logic [3:0]  m_sel  [NA];
  logic        m_en   [NA];
  logic [31:0] m_addr [NA];
  logic        m_wr   [NA];
  logic [31:0] m_wd   [NA];
  logic        m_rv   [NA];
  logic        m_re   [NA];
  logic        m_rrd  [NA];
  logic [31:0] ph     [NA];

  task automatic random_run(input int d, input int aw);
    int   nr, idx, r;
    bit   hold;
    logic acc, exp_rdy;
    for (int i = 0; i < NA; i++) begin
      m_sel[i] = '0; m_en[i] = 0; m_addr[i] = '0; m_wr[i] = 0; m_wd[i] = '0;
      m_rv[i] = 0; m_re[i] = 0; m_rrd[i] = 0; ph[i] = '0;
    end
    nr   = 0;
    hold = 0;
    for (int c = 0; c < NCYC; c++) begin
      if (!hold) begin
        if (c < NCYC - 30 && $urandom_range(0, 3) != 0) begin
          idx          = $urandom_range(0, 5);
          req_addr[d]  = {idx[19:0], 12'($urandom)};
          req_write[d] = 1'($urandom);
          req_wdata[d] = $urandom;
          req_valid[d] = 1'b1;
        end else begin
          req_valid[d] = 1'b0;
        end
      end
      Prdata[d] = $urandom;
      ph[c]     = Prdata[d];
      #4;
      exp_rdy = (c >= nr);
      chk("rnd_ready", req_ready[d], exp_rdy);
      chk("rnd_sel", Pselx[d], m_sel[c]);
      chk("rnd_en", Penable[d], m_en[c]);
      if (m_sel[c] != 0) begin
        chk("rnd_paddr", Paddr[d], m_addr[c]);
        chk("rnd_pwrite", Pwrite[d], m_wr[c]);
        chk("rnd_pwdata", Pwdata[d], m_wd[c]);
      end
      chk("rnd_rspv", rsp_valid[d], m_rv[c]);
      if (m_rv[c]) begin
        chk("rnd_err", rsp_err[d], m_re[c]);
        chk("rnd_rdata", rsp_rdata[d], (m_re[c] || !m_rrd[c]) ? 32'h0 : ph[c-1]);
      end
      acc = req_valid[d] && exp_rdy;
      if (acc) begin
        if (req_addr[d][31:12] < 4) begin
          for (int k = c + 1; k <= c + 2 + aw; k++) begin
            m_sel[k]  = 4'b0001 << req_addr[d][13:12];
            m_addr[k] = req_addr[d];
            m_wr[k]   = req_write[d];
            m_wd[k]   = req_wdata[d];
            m_en[k]   = (k >= c + 2);
          end
          r        = c + 3 + aw;
          m_rv[r]  = 1;
          m_re[r]  = 0;
          m_rrd[r] = !req_write[d];
          nr       = c + 2 + aw;
        end else begin
          // Error goes in the first free response slot after acceptance.
          r = c + 1;
          while (m_rv[r]) r++;
          m_rv[r] = 1;
          m_re[r] = 1;
          nr      = r;
        end
      end
      hold = req_valid[d] && !acc;
      tick();
    end
    req_valid[d] = 1'b0;
  endtask

  vec_t tbl [7];
  vec_t va;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] bsel [1:5];
    logic       ben  [1:5];
    logic       brv  [1:5];

    tbl[0] = '{32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 32'hAAAA_5555, 4'b0010, 1'b0, 32'h0};
    tbl[1] = '{32'h0000_0010, 1'b0, 32'h0,         32'hCAFE_F00D, 4'b0001, 1'b0, 32'hCAFE_F00D};
    tbl[2] = '{32'h0000_2FFC, 1'b0, 32'h0,         32'h0BAD_C0DE, 4'b0100, 1'b0, 32'h0BAD_C0DE};
    tbl[3] = '{32'h0000_5000, 1'b1, 32'h1357_9BDF, 32'h1111_2222, 4'b0000, 1'b1, 32'h0};
    tbl[4] = '{32'h0000_4000, 1'b0, 32'h0,         32'h3333_4444, 4'b0000, 1'b1, 32'h0};
    tbl[5] = '{32'hFFFF_F000, 1'b0, 32'h0,         32'h5555_6666, 4'b0000, 1'b1, 32'h0};
    tbl[6] = '{32'h0000_3FFF, 1'b0, 32'h0,         32'h8765_4321, 4'b1000, 1'b0, 32'h8765_4321};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b1; req_addr[d] = 32'h0000_1000;
      req_write[d] = 1'b1; req_wdata[d] = 32'h0; Prdata[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #5;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", req_ready[d], 0);
      chk("rst_sel", Pselx[d], 0);
      chk("rst_en", Penable[d], 0);
      chk("rst_pwrite", Pwrite[d], 0);
      chk("rst_paddr", Paddr[d], 0);
      chk("rst_pwdata", Pwdata[d], 0);
      chk("rst_rspv", rsp_valid[d], 0);
      chk("rst_err", rsp_err[d], 0);
      chk("rst_rdata", rsp_rdata[d], 0);
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req_valid[d] = 1'b0;
    end
    tick();

    // Vector table on the zero-wait instance.
    for (int i = 0; i < 7; i++) begin
      single(0, 0, tbl[i], $sformatf("vec%0d", i));
    end

    // Read with two extra ACCESS cycles.
    va = '{32'h0000_3000, 1'b0, 32'h0, 32'h1234_5678, 4'b1000, 1'b0, 32'h1234_5678};
    single(1, 2, va, "rd_wait2");

    // Back-to-back writes to slaves 0 then 2 with req_valid held.
    bsel = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0000};
    ben  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    brv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    req_valid[0] = 1'b1; req_addr[0] = 32'h0000_0008;
    req_write[0] = 1'b1; req_wdata[0] = 32'h1111_1111;
    #4;
    chk("b2b_ready0", req_ready[0], 1);
    tick();
    req_addr[0] = 32'h0000_2010; req_wdata[0] = 32'h2222_2222;
    for (int k = 1; k <= 5; k++) begin
      #4;
      chk("b2b_sel", Pselx[0], bsel[k]);
      chk("b2b_en", Penable[0], ben[k]);
      chk("b2b_rspv", rsp_valid[0], brv[k]);
      if (k == 1) chk("b2b_ready1", req_ready[0], 0);
      if (k == 2) chk("b2b_ready2", req_ready[0], 1);
      if (k == 3) begin
        chk("b2b_paddr", Paddr[0], 32'h0000_2010);
        chk("b2b_pwdata", Pwdata[0], 32'h2222_2222);
      end
      if (brv[k]) begin
        chk("b2b_err", rsp_err[0], 0);
        chk("b2b_rdata", rsp_rdata[0], 0);
      end
      tick();
      if (k == 2) req_valid[0] = 1'b0;
    end

    // Out-of-range request accepted in the last ACCESS cycle of a read.
    req_valid[0] = 1'b1; req_addr[0] = 32'h0000_1000;
    req_write[0] = 1'b0; Prdata[0] = 32'h5A5A_A5A5;
    #4;
    chk("defer_ready0", req_ready[0], 1);
    tick();
    req_addr[0] = 32'h0000_7000;
    #4;
    chk("defer_ready1", req_ready[0], 0);
    tick();
    #4;
    chk("defer_ready2", req_ready[0], 1);
    tick();
    req_valid[0] = 1'b0;
    #4;
    chk("defer_rspv3", rsp_valid[0], 1);
    chk("defer_err3", rsp_err[0], 0);
    chk("defer_rdata3", rsp_rdata[0], 32'h5A5A_A5A5);
    chk("defer_ready3", req_ready[0], 0);
    chk("defer_sel3", Pselx[0], 0);
    tick();
    #4;
    chk("defer_rspv4", rsp_valid[0], 1);
    chk("defer_err4", rsp_err[0], 1);
    chk("defer_rdata4", rsp_rdata[0], 0);
    chk("defer_sel4", Pselx[0], 0);
    chk("defer_ready4", req_ready[0], 1);
    tick();
    #4;
    chk("defer_rspv5", rsp_valid[0], 0);
    tick();

    // Reset during ACCESS drops the transfer without a response.
    req_valid[1] = 1'b1; req_addr[1] = 32'h0000_2000;
    req_write[1] = 1'b0; Prdata[1] = 32'h0F0F_0F0F;
    #4;
    chk("rstmid_ready0", req_ready[1], 1);
    tick();
    req_valid[1] = 1'b0;
    tick();
    rst[1] = 1'b1;
    #4;
    chk("rstmid_en2", Penable[1], 1);
    chk("rstmid_ready2", req_ready[1], 0);
    tick();
    rst[1] = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      #4;
      chk("rstmid_sel", Pselx[1], 0);
      chk("rstmid_en", Penable[1], 0);
      chk("rstmid_rspv", rsp_valid[1], 0);
      tick();
    end
    va = '{32'h0000_0004, 1'b1, 32'hFACE_B00C, 32'h0, 4'b0001, 1'b0, 32'h0};
    single(1, 2, va, "after_rst");

    random_run(0, 0);
    random_run(1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_bridge_ctrl.md
Name: apb_bridge_ctrl

Overview:
APB-side sequencer of the AHB-to-APB bridge. It accepts single transfer requests from the AHB slave front-end over a valid/ready handshake and decodes the target slave from the address. It then drives the APB SETUP/ACCESS phases (Pselx, Penable, Paddr, Pwrite, Pwdata), samples Prdata, and returns one in-order response per request. Out-of-range addresses are rejected with an error response and no APB cycle.

Parameters:
ADDR_W, 32, width of req_addr and Paddr
DATA_W, 32, width of write/read data
NUM_SLAVES, 4, number of APB slaves; width of Pselx
SEL_LSB, 12, slave index = req_addr[ADDR_W-1:SEL_LSB]; valid when < NUM_SLAVES
ACCESS_WAIT, 0, extra ACCESS cycles before Prdata is sampled (0..15)

Ports:
clk  in  1  bridge clock, all logic on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_addr  in  ADDR_W  transfer address
req_write  in  1  1=write, 0=read
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_err  out  1  qualifies rsp_valid; 1=decode error
rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads; 0 for writes and errors
Pselx  out  NUM_SLAVES  one-hot APB select
Penable  out  1  APB enable (ACCESS phase)
Pwrite  out  1  APB direction
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data
Prdata  in  DATA_W  APB read data

Behaviour:
- One clock (clk); reset rst is synchronous and active-high. All APB outputs and rsp_* are registered.
- Reset values: Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0. State=IDLE, wait counter=0, err_pend=0. req_ready=0 while rst=1.
- States: IDLE, SETUP, ACCESS. req_ready is combinational: 1 in IDLE, or in ACCESS when cnt==0 (the last ACCESS cycle); otherwise 0.
- IDLE, accepting an in-range request: next cycle is SETUP with Pselx=onehot(idx), Penable=0, and Paddr/Pwrite/Pwdata latched from the request.
- IDLE, accepting an out-of-range request: stay in IDLE, Pselx stays 0, and rsp_valid=1, rsp_err=1 on the next cycle.
- SETUP → ACCESS unconditionally. Penable=1, cnt=ACCESS_WAIT, and Pselx/Paddr/Pwrite/Pwdata are held stable.
- ACCESS with cnt!=0: decrement cnt and stay in ACCESS.
- ACCESS with cnt==0 (last cycle): Prdata is sampled at this edge. On the next cycle rsp_valid=1, rsp_err=0, and rsp_rdata=Prdata for a read or 0 for a write.
  - In-range request accepted in the same cycle → SETUP directly (Penable drops to 0, Pselx switches to the new slave). Back-to-back throughput is one transfer per 2+ACCESS_WAIT cycles.
  - Otherwise → IDLE with Pselx=0, Penable=0. Paddr/Pwrite/Pwdata hold their last values.
  - Out-of-range request accepted in the last ACCESS cycle: set err_pend and go to IDLE. The current transfer's response comes first; the error response follows one cycle later. req_ready=0 while err_pend=1.
- Responses are strictly in request order, at most one per cycle. rsp_valid is never asserted two cycles for one request.
- Transfer latency, request accept to rsp_valid, is 3+ACCESS_WAIT cycles. Error latency is 1 cycle, or 2 when deferred by err_pend.
- Pselx is never multi-hot. Penable=1 only when Pselx!=0 and the preceding cycle was SETUP or ACCESS of the same transfer.
- Reset mid-transfer: all outputs take reset values at the next edge. The in-flight request is dropped with no response; err_pend is cleared.
- The requester must hold req_* stable while req_valid=1 and req_ready=0. The block does not check this.

Decomposition:
- Package apb_bridge_pkg holds:
  - state enum apb_state_e {IDLE, SETUP, ACCESS}
  - the ACCESS_WAIT counter width constant (4)
  - a response struct {err, rdata}
- Sub-module apb_slave_decode: combinational; input address; outputs one-hot select and hit flag. Parameterised by ADDR_W, SEL_LSB, NUM_SLAVES.

Test Plan:
- Reset, then a single write (addr 0x0000_1004, wdata 0xDEAD_BEEF) → SETUP cycle with Pselx=4'b0010, Penable=0; next cycle Penable=1; rsp_valid pulse 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read addr 0x0000_3000, Prdata=0x1234_5678, ACCESS_WAIT=2 → Pselx=4'b1000, ACCESS held 3 cycles, rsp_rdata=0x1234_5678 exactly 5 cycles after accept.
- Back-to-back writes to slaves 0 then 2 with req_valid held → Penable sequence 0,1,0,1; Pselx 0001→0100 with no IDLE gap; two rsp_valid pulses 2 cycles apart.
- Request addr 0x0000_5000 from IDLE → no Pselx activity; rsp_valid=1, rsp_err=1 the next cycle.
- Out-of-range request presented in the last ACCESS cycle of a read → read response, then error response on the following cycle; req_ready=0 during that cycle.
- rst asserted during ACCESS → next cycle Pselx=0, Penable=0, no rsp_valid; a new request after rst is released completes normally.
